arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
Parametrised successor to the per-core PS/2 and joystick button logic in the arcade emu tops. It decodes `ps2_key` events against a compile-time keymap and ORs in mapped joystick bits from two pads. It drives a registered button vector into the game core, with per-button autofire and a timed coin-pulse generator. It sits in clk_sys between hps_io and the arcade core (e.g. defender).

Parameters:
- NUM_BTN, 12, number of game buttons driven out (1..32).
- KEYS_PER_BTN, 2, keymap slots per button (1..4).
- KEYMAP, all zero, packed NUM_BTN*KEYS_PER_BTN entries of 10 bits {ign_ext, code[8:0]}; entry index = btn*KEYS_PER_BTN+slot; code 0 = unused slot.
- JOYMAP, all 5'h1F, packed NUM_BTN entries of 5 bits; joystick bit index ORed into that button; 31 = none.
- AF_MASK, 0, NUM_BTN bits; buttons subject to autofire.
- AF_HALF, 400000, autofire half-period in clk_sys cycles.
- COIN_BTN, 0, button index whose rising edge requests a coin.
- COIN_CYCLES, 2000000, coin_out high time in cycles.
- COIN_GAP, 2000000, minimum coin_out low time after a pulse.

Ports:
- clk_sys, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- ps2_key, in, 11, {toggle, pressed, code[8:0]} from hps_io.
- joystick_0, in, 16, pad 0 bits.
- joystick_1, in, 16, pad 1 bits.
- autofire_en, in, 1, OSD autofire enable; level, may change any cycle.
- btn_out, out, NUM_BTN, registered button levels to core.
- coin_out, out, 1, registered coin pulse.
- key_event, out, 1, one-cycle strobe per accepted PS/2 event (matched or not).

Behaviour:
- Reset (async assert, sync release): btn_out=0, coin_out=0, key_event=0, all slot states 0, autofire phase 0, counters 0, primed=0.
- Toggle detect: first clock after reset release, capture ps2_key[10] into old_toggle, set primed, no event. Thereafter event when primed and ps2_key[10]!=old_toggle; old_toggle updated every cycle.
- Slot match: code==entry.code, or, if ign_ext, code[7:0]==entry.code[7:0]. Unused slots never match.
- A matching slot stores `pressed`. One event may update several slots. Repeats are idempotent.
- Per-slot state is the fix over the legacy single-reg scheme: releasing one of two keys mapped to a button leaves the button held while the other slot is still 1.
- raw[i] = OR of slot states[i] | joy[JOYMAP[i]], with joy = joystick_0 | joystick_1.
- Latency: event edge on cycle N -> key_event and slot state set at N+1 -> btn_out at N+2. Joystick change -> btn_out 1 cycle later.
- Autofire: free-running counter 0..AF_HALF-1; phase toggles on wrap.
  - btn_out[i] = raw[i] & (phase | ~AF_MASK[i] | ~autofire_en).
  - Disabling autofire mid-hold restores the level next cycle.
- Coin FSM, states IDLE, PULSE, GAP:
  - IDLE: on rising edge of raw[COIN_BTN] -> PULSE, coin_out=1, counter cleared.
  - PULSE: after exactly COIN_CYCLES cycles high -> GAP, coin_out=0.
  - GAP: after COIN_GAP cycles -> IDLE.
  - Edges during PULSE or GAP are dropped, not queued. Holding the button yields exactly one pulse.
- Reset mid-pulse: coin_out drops immediately (async) and the FSM returns to IDLE.
- A toggle change on the release cycle of reset is absorbed by priming, not decoded.

Decomposition:
- Package arcade_input_pkg:
  - KEY_ENTRY_W=10, KEY_NONE=10'h000, JOY_NONE=5'h1F.
  - Common scancode constants: KEY_UP=10'h275, KEY_SPACE=10'h029, KEY_F1=10'h005, KEY_LSHIFT=10'h012, KEY_CTRL=10'h214 with ign_ext set.
  - Function key_match(entry, code).
- One sub-module: coin_pulser (edge detect + IDLE/PULSE/GAP FSM + counter), parametrised on COIN_CYCLES and COIN_GAP.

Test Plan:
- Thrust mapped to slots 0x6B/0x74: press 0x6B, press 0x74, release 0x6B -> btn_out[thrust] stays 1; release 0x74 -> 0 at N+2.
- ign_ext entry 0x214, event code 0x014 pressed -> button 1 at N+2, key_event strobe at N+1; code 0x114 release -> button 0.
- ps2_key[10]=1 held through reset release -> no key_event, btn_out=0; next toggle -> decoded normally.
- AF_MASK bit 5 with AF_HALF=4, autofire_en=1, joystick_0[5] held -> btn_out[5] square wave 4 high / 4 low; autofire_en=0 -> steady 1 next cycle.
- COIN_CYCLES=10, COIN_GAP=6: press start -> coin_out high exactly 10 cycles; re-press at +12 -> ignored; re-press at +17 -> new pulse.
- reset_n low during PULSE -> coin_out=0 same cycle; after release, start still held -> no pulse until a fresh rising edge.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared keymap constants, coin FSM states and match helpers
package arcade_input_pkg;

    localparam int         KEY_ENTRY_W = 10;
    localparam logic [9:0] KEY_NONE    = 10'h000;
    localparam logic [4:0] JOY_NONE    = 5'h1F;

    // Keymap entries are {ign_ext, code[8:0]}
    localparam logic [9:0] KEY_UP     = 10'h275;
    localparam logic [9:0] KEY_SPACE  = 10'h029;
    localparam logic [9:0] KEY_F1     = 10'h005;
    localparam logic [9:0] KEY_LSHIFT = 10'h012;
    localparam logic [9:0] KEY_CTRL   = 10'h214;

    typedef enum logic [1:0] {
        COIN_ST_IDLE  = 2'd0,
        COIN_ST_PULSE = 2'd1,
        COIN_ST_GAP   = 2'd2
    } coin_state_e;

    function automatic logic key_match(input logic [KEY_ENTRY_W-1:0] entry,
                                       input logic [8:0]             code);
        logic hit;
        hit = 1'b0;
        if (entry[8:0] != 9'h000) begin
            hit = (code == entry[8:0]) || (entry[9] && (code[7:0] == entry[7:0]));
        end
        return hit;
    endfunction

    // Joystick indices 16..31 select nothing
    function automatic logic joy_pick(input logic [15:0] joy,
                                      input logic [4:0]  idx);
        return (idx[4] == 1'b0) ? joy[idx[3:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// rtl/arcade_input_mapper_coin_pulser.sv - rising-edge coin request to fixed-width pulse with lockout gap
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES = 2000000,
    parameter int COIN_GAP    = 2000000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic coin_req,
    output logic coin_out
);

    localparam int PULSE_N = (COIN_CYCLES > 0) ? COIN_CYCLES : 1;
    localparam int GAP_N   = (COIN_GAP > 0) ? COIN_GAP : 1;
    localparam int MAX_N   = (PULSE_N > GAP_N) ? PULSE_N : GAP_N;
    localparam int CNT_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_N - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_N - 1);

    coin_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             primed_q, primed_d;
    logic             coin_q, coin_d;
    logic             rise;

    // A request already high when reset releases is not an edge
    assign rise = primed_q & coin_req & ~prev_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        coin_d   = coin_q;
        prev_d   = coin_req;
        primed_d = 1'b1;
        case (state_q)
            COIN_ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = COIN_ST_PULSE;
                    coin_d  = 1'b1;
                end
            end
            COIN_ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = COIN_ST_GAP;
                    coin_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            COIN_ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = COIN_ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = COIN_ST_IDLE;
                coin_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= COIN_ST_IDLE;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
            coin_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            coin_q   <= coin_d;
        end
    end

    assign coin_out = coin_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 keymap and joystick merge into registered arcade buttons with autofire and coin
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_BTN      = 12,
    parameter int KEYS_PER_BTN = 2,
    parameter logic [NUM_BTN*KEYS_PER_BTN*KEY_ENTRY_W-1:0] KEYMAP = '0,
    parameter logic [NUM_BTN*5-1:0] JOYMAP = {NUM_BTN{JOY_NONE}},
    parameter logic [NUM_BTN-1:0]   AF_MASK = '0,
    parameter int AF_HALF     = 400000,
    parameter int COIN_BTN    = 0,
    parameter int COIN_CYCLES = 2000000,
    parameter int COIN_GAP    = 2000000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [10:0]        ps2_key,
    input  logic [15:0]        joystick_0,
    input  logic [15:0]        joystick_1,
    input  logic               autofire_en,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               coin_out,
    output logic               key_event
);

    localparam int NUM_SLOTS = NUM_BTN * KEYS_PER_BTN;
    localparam int AF_W      = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_HALF - 1);

    logic                 old_toggle_q, old_toggle_d;
    logic                 primed_q, primed_d;
    logic                 key_event_q, key_event_d;
    logic [NUM_SLOTS-1:0] slot_q, slot_d;
    logic [AF_W-1:0]      af_cnt_q, af_cnt_d;
    logic                 af_phase_q, af_phase_d;
    logic [NUM_BTN-1:0]   btn_q, btn_d;
    logic [NUM_BTN-1:0]   raw;
    logic [NUM_BTN-1:0]   af_gate;
    logic [15:0]          joy;
    logic                 ps2_strobe;

    // The first cycle after reset only learns the toggle level
    assign ps2_strobe = primed_q & (ps2_key[10] ^ old_toggle_q);
    assign joy        = joystick_0 | joystick_1;

    always_comb begin
        old_toggle_d = ps2_key[10];
        primed_d     = 1'b1;
        key_event_d  = ps2_strobe;
        slot_d       = slot_q;
        if (ps2_strobe) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (key_match(KEYMAP[s*KEY_ENTRY_W +: KEY_ENTRY_W], ps2_key[8:0])) begin
                    slot_d[s] = ps2_key[9];
                end
            end
        end
    end

    // Each slot holds its own key so one release cannot drop a button another key still holds
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            raw[i] = (|slot_q[i*KEYS_PER_BTN +: KEYS_PER_BTN]) | joy_pick(joy, JOYMAP[i*5 +: 5]);
        end
    end

    always_comb begin
        af_cnt_d   = (af_cnt_q == AF_LAST) ? '0 : af_cnt_q + 1'b1;
        af_phase_d = af_phase_q ^ (af_cnt_q == AF_LAST);
        af_gate    = {NUM_BTN{af_phase_q}} | ~AF_MASK | {NUM_BTN{~autofire_en}};
        btn_d      = raw & af_gate;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_toggle_q <= 1'b0;
            primed_q     <= 1'b0;
            key_event_q  <= 1'b0;
            slot_q       <= '0;
            af_cnt_q     <= '0;
            af_phase_q   <= 1'b0;
            btn_q        <= '0;
        end else begin
            old_toggle_q <= old_toggle_d;
            primed_q     <= primed_d;
            key_event_q  <= key_event_d;
            slot_q       <= slot_d;
            af_cnt_q     <= af_cnt_d;
            af_phase_q   <= af_phase_d;
            btn_q        <= btn_d;
        end
    end

    coin_pulser #(
        .COIN_CYCLES (COIN_CYCLES),
        .COIN_GAP    (COIN_GAP)
    ) u_coin_pulser (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .coin_req (raw[COIN_BTN]),
        .coin_out (coin_out)
    );

    assign btn_out   = btn_q;
    assign key_event = key_event_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for arcade_input_mapper against a cycle-indexed reference model
module tb_arcade_input_mapper;
    import arcade_input_pkg::*;

    localparam int NB  = 8;
    localparam int KP  = 2;
    localparam int AFH = 4;
    localparam int CC  = 10;
    localparam int CG  = 6;
    localparam int CB  = 4;

    // btn0 thrust (6B/74), btn1 ctrl ign_ext, btn2 space, btn3 up, btn4 coin/start, btn5 autofire, btn6 shifts
    localparam logic [NB*KP*10-1:0] KM = {
        10'h000, 10'h000, 10'h059, KEY_LSHIFT, 10'h000, 10'h000, 10'h000, KEY_F1,
        10'h000, KEY_UP, 10'h000, KEY_SPACE, 10'h000, KEY_CTRL, 10'h074, 10'h06B};
    localparam logic [NB*5-1:0] JM = {5'd31, 5'd6, 5'd5, 5'd4, 5'd0, 5'd31, 5'd3, 5'd2};
    localparam logic [NB-1:0]   AFM = 8'h20;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   ps2_key = '0;
    logic [15:0]   joystick_0 = '0;
    logic [15:0]   joystick_1 = '0;
    logic          autofire_en = 1'b0;
    logic [NB-1:0] btn_out;
    logic          coin_out;
    logic          key_event;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_BTN(NB), .KEYS_PER_BTN(KP), .KEYMAP(KM), .JOYMAP(JM), .AF_MASK(AFM),
        .AF_HALF(AFH), .COIN_BTN(CB), .COIN_CYCLES(CC), .COIN_GAP(CG)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .autofire_en(autofire_en),
        .btn_out(btn_out), .coin_out(coin_out), .key_event(key_event)
    );

    typedef struct packed {
        logic [NB-1:0] btn;
        logic          coin;
        logic          kev;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    logic          st_rst = 1'b0;
    logic [10:0]   st_key = 11'h400;
    logic [15:0]   st_j0 = '0;
    logic [15:0]   st_j1 = '0;
    logic          st_af = 1'b0;

    bit            m_slot [NB*KP];
    bit            m_old, m_primed, m_prev_coin;
    bit [NB-1:0]   m_btn;
    bit            m_coin, m_kev;
    int            m_k, m_pstart, m_next_ok;

    task automatic m_reset();
        foreach (m_slot[e]) m_slot[e] = 1'b0;
        m_old = 0; m_primed = 0; m_prev_coin = 0;
        m_btn = '0; m_coin = 0; m_kev = 0;
        m_k = 0; m_pstart = -1000; m_next_ok = 0;
    endtask

    // m_k counts clock edges since reset release; outputs describe the state after the next edge
    task automatic m_advance();
        bit [NB-1:0] raw;
        bit [15:0]   joy;
        bit [9:0]    ent;
        bit [4:0]    idx;
        bit          phase;
        joy = st_j0 | st_j1;
        for (int i = 0; i < NB; i++) begin
            raw[i] = 1'b0;
            for (int s = 0; s < KP; s++) raw[i] = raw[i] | m_slot[i*KP+s];
            idx = JM[i*5 +: 5];
            if (idx[4] == 1'b0) raw[i] = raw[i] | joy[idx[3:0]];
        end
        phase = ((m_k / AFH) % 2) == 1;
        for (int i = 0; i < NB; i++) m_btn[i] = raw[i] && (phase || !AFM[i] || !st_af);
        m_kev = m_primed && (st_key[10] != m_old);
        if (m_kev) begin
            for (int e = 0; e < NB*KP; e++) begin
                ent = KM[e*10 +: 10];
                if (ent[8:0] != 0 && (st_key[8:0] == ent[8:0] || (ent[9] && st_key[7:0] == ent[7:0])))
                    m_slot[e] = st_key[9];
            end
        end
        m_old = st_key[10];
        m_primed = 1;
        if (m_k > 0 && raw[CB] && !m_prev_coin && m_k >= m_next_ok) begin
            m_pstart  = m_k + 1;
            m_next_ok = m_k + 1 + CC + CG;
        end
        m_prev_coin = raw[CB];
        m_k++;
        m_coin = (m_k >= m_pstart) && (m_k < m_pstart + CC);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        reset_n = st_rst; ps2_key = st_key; joystick_0 = st_j0; joystick_1 = st_j1; autofire_en = st_af;
        if (!st_rst) m_reset();
        exp_q.push_back({m_btn, m_coin, m_kev});
        if (st_rst) m_advance();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic key(input bit p, input bit [8:0] code);
        st_key = {~st_key[10], p, code};
        tick();
    endtask

    always @(negedge clk_sys) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (btn_out !== mon_e.btn) begin
                n_err++;
                $display("FAIL btn_out @%0t: got %h expected %h", $time, btn_out, mon_e.btn);
            end
            if (coin_out !== mon_e.coin) begin
                n_err++;
                $display("FAIL coin_out @%0t: got %b expected %b", $time, coin_out, mon_e.coin);
            end
            if (key_event !== mon_e.kev) begin
                n_err++;
                $display("FAIL key_event @%0t: got %b expected %b", $time, key_event, mon_e.kev);
            end
        end
    end

    bit [8:0] pool [12] = '{9'h06B, 9'h074, 9'h014, 9'h114, 9'h029, 9'h129,
                             9'h075, 9'h175, 9'h005, 9'h012, 9'h059, 9'h0AA};

    initial begin
        m_reset();
        // toggle held high across reset release must not decode
        idle(3);
        st_rst = 1'b1;
        idle(4);
        // two keys on one button
        key(1, 9'h06B); idle(2);
        key(1, 9'h074); idle(2);
        key(0, 9'h06B); idle(3);
        key(0, 9'h074); idle(3);
        // ign_ext entry, unmatched key, repeats, back-to-back events
        key(1, 9'h014); idle(2);
        key(0, 9'h114); idle(2);
        key(1, 9'h1AA); idle(1);
        key(1, 9'h029); key(1, 9'h029); key(0, 9'h129); key(0, 9'h029); idle(2);
        key(1, 9'h175); key(1, 9'h012); key(1, 9'h059); key(0, 9'h012); idle(2);
        key(0, 9'h059); key(0, 9'h075); idle(2);
        // autofire square wave, then disable mid-hold
        st_af = 1'b1; st_j0[5] = 1'b1; idle(20);
        st_af = 1'b0; idle(3);
        st_af = 1'b1; idle(6);
        st_j0[5] = 1'b0; idle(2);
        // coin pulse with re-presses in the gap and after it
        st_j0[4] = 1'b1; tick();
        idle(3); st_j0[4] = 1'b0; idle(8);
        st_j0[4] = 1'b1; tick();
        st_j0[4] = 1'b0; idle(4);
        st_j0[4] = 1'b1; tick();
        idle(3); st_j0[4] = 1'b0; idle(20);
        // reset mid-pulse, start held through release, toggle flip on release cycle
        st_j1[4] = 1'b1; idle(4);
        st_rst = 1'b0; idle(2);
        st_rst = 1'b1; st_key[10] = ~st_key[10]; tick();
        idle(20);
        st_j1[4] = 1'b0; idle(2);
        st_j1[4] = 1'b1; idle(14);
        st_j1[4] = 1'b0; idle(2);
        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) st_key = {~st_key[10], 1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)]};
            else if (r < 27) st_key = {~st_key[10], 1'($urandom_range(0, 1)), 9'($urandom())};
            if ($urandom_range(0, 9) == 0) st_j0[$urandom_range(0, 7)] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) st_j1[$urandom_range(0, 7)] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) st_af = ~st_af;
            st_rst = ($urandom_range(0, 149) != 0);
            tick();
        end
        st_rst = 1'b1;
        idle(4);
        @(negedge clk_sys);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
